// File: rtl/aes_ctr_sched_if.sv
// Handshake bundle between the CTR scheduler, the mode control, the counter FSM and the cipher core.
interface aes_ctr_sched_if #(
  parameter int NumBlkW = 16
);
  logic               start_i;
  logic [NumBlkW-1:0] num_blocks_i;
  logic               clear_i;
  logic               busy_o;
  logic               done_o;
  logic [NumBlkW-1:0] blk_cnt_o;
  logic               alert_o;
  logic               ctr_incr_o;
  logic               ctr_ready_i;
  logic               ctr_alert_i;
  logic               cipher_in_valid_o;
  logic               cipher_in_ready_i;
  logic               cipher_out_valid_i;
  logic               cipher_out_ready_o;

  modport slave (
    input  start_i, num_blocks_i, clear_i, ctr_ready_i, ctr_alert_i,
           cipher_in_ready_i, cipher_out_valid_i,
    output busy_o, done_o, blk_cnt_o, alert_o, ctr_incr_o,
           cipher_in_valid_o, cipher_out_ready_o
  );

  modport master (
    output start_i, num_blocks_i, clear_i, ctr_ready_i, ctr_alert_i,
           cipher_in_ready_i, cipher_out_valid_i,
    input  busy_o, done_o, blk_cnt_o, alert_o, ctr_incr_o,
           cipher_in_valid_o, cipher_out_ready_o
  );
endinterface

// File: rtl/aes_ctr_sched.sv
// AES-CTR block sequencer: feeds the cipher core, steps the counter FSM with a watchdog,
// collects keystream blocks and latches any fault into a terminal alert state.
//   state      | meaning
//   IDLE       | waiting for start_i
//   LOAD       | counter value offered to the cipher core
//   INCR_REQ   | waiting for counter FSM ready, then pulse ctr_incr_o
//   INCR_WAIT  | counter FSM busy; watchdog running
//   OUT        | accepting one keystream block
//   ERROR      | terminal, alert_o high until reset
module aes_ctr_sched #(
  parameter int NumBlkW     = 16,
  parameter int IncrTimeout = 32,
  parameter int TmoW        = $clog2(IncrTimeout + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  aes_ctr_sched_if.slave   bus
);

  typedef enum logic [5:0] {
    ST_IDLE      = 6'b000001,
    ST_LOAD      = 6'b000010,
    ST_INCR_REQ  = 6'b000100,
    ST_INCR_WAIT = 6'b001000,
    ST_OUT       = 6'b010000,
    ST_ERROR     = 6'b100000
  } state_e;

  // Watchdog counts down from IncrTimeout-1; the load value marks the first wait cycle.
  localparam logic [TmoW-1:0] TmoLoad = TmoW'(IncrTimeout - 1);

  state_e             state_q, state_d;
  logic [NumBlkW-1:0] cnt_q, cnt_d;
  logic [NumBlkW-1:0] num_q, num_d;
  logic [TmoW-1:0]    wdog_q, wdog_d;
  logic               done_q, done_d;
  logic               alert_q, alert_d;
  logic [NumBlkW-1:0] cnt_inc;
  logic               legal;

  assign cnt_inc = cnt_q + NumBlkW'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      wdog_q  <= '0;
      done_q  <= 1'b0;
      alert_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      wdog_q  <= wdog_d;
      done_q  <= done_d;
      alert_q <= alert_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    wdog_d  = wdog_q;
    done_d  = 1'b0;
    legal   = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i) begin
          if (bus.num_blocks_i != '0) begin
            num_d   = bus.num_blocks_i;
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (bus.cipher_in_ready_i) state_d = ST_INCR_REQ;
      end
      ST_INCR_REQ: begin
        if (bus.ctr_ready_i) begin
          wdog_d  = TmoLoad;
          state_d = ST_INCR_WAIT;
        end
      end
      ST_INCR_WAIT: begin
        // Ready still high right after the request means the counter FSM ignored it.
        if (bus.ctr_ready_i) begin
          state_d = (wdog_q == TmoLoad) ? ST_ERROR : ST_OUT;
        end else if (wdog_q == '0) begin
          state_d = ST_ERROR;
        end else begin
          wdog_d = wdog_q - TmoW'(1);
        end
      end
      ST_OUT: begin
        if (bus.cipher_out_valid_i) begin
          cnt_d = cnt_inc;
          if (cnt_inc == num_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_ERROR: begin
        legal = 1'b0;
      end
      default: begin
        legal   = 1'b0;
        state_d = ST_ERROR;
      end
    endcase

    if (bus.ctr_alert_i) begin
      state_d = ST_ERROR;
      cnt_d   = cnt_q;
      num_d   = num_q;
      done_d  = 1'b0;
    end else if (bus.clear_i && legal) begin
      state_d = ST_IDLE;
      cnt_d   = cnt_q;
      num_d   = num_q;
      done_d  = 1'b0;
    end

    alert_d = (state_d == ST_ERROR);
  end

  always_comb begin
    bus.busy_o             = (state_q != ST_IDLE);
    bus.cipher_in_valid_o  = (state_q == ST_LOAD);
    bus.cipher_out_ready_o = (state_q == ST_OUT);
    bus.ctr_incr_o         = (state_q == ST_INCR_REQ) && bus.ctr_ready_i;
    bus.done_o             = done_q;
    bus.alert_o            = alert_q;
    bus.blk_cnt_o          = cnt_q;
  end

endmodule
